// File: rtl/led_pkg.sv
// Shared definitions for the status-LED pattern controller: mode encoding,
// CODE-pattern state enum and PWM width.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_CODE  = 2'd3;

  localparam int LED_PWM_W = 8;

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_OFF   = 2'd1,
    ST_PAUSE = 2'd2
  } code_st_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// Free-running PWM counter and duty compare used to dim the status LED.
// Only instantiated when LED_DIM_EN is defined.
module led_pwm_gate
  import led_pkg::*;
(
  input  logic                 i_sys_clk,
  input  logic                 i_rst,
  input  logic [LED_PWM_W-1:0] i_duty,
  output logic                 o_gate
);

  logic [LED_PWM_W-1:0] pwm_cnt_q;
  logic [LED_PWM_W-1:0] pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + LED_PWM_W'(1);
  assign o_gate    = (pwm_cnt_q < i_duty);

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Status-LED pattern controller: OFF / ON / BLINK / N-pulse CODE, timed in ticks.
// Optional dimming via PWM when the LED_DIM_EN macro is defined.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int BLINK_TICKS = 5,
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 3,
  parameter int PAUSE_TICKS = 10
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_mode_vld,
  input  logic [1:0]           i_mode,
  input  logic [3:0]           i_code,
  input  logic [LED_PWM_W-1:0] i_duty,
  output logic                 o_led,
  output logic                 o_frame_done
);

  localparam int CNT_W = $clog2(max4(BLINK_TICKS, ON_TICKS, OFF_TICKS, PAUSE_TICKS) + 1);

  localparam logic [CNT_W-1:0] TICK_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);

  logic [1:0]       mode_q, mode_d;
  logic [3:0]       code_q, code_d;
  code_st_e         state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       pulse_cnt_q, pulse_cnt_d;
  logic             blink_q, blink_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic             led_raw;
  logic             led_gate;

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q      <= MODE_OFF;
      code_q      <= '0;
      state_q     <= ST_ON;
      tick_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      blink_q     <= 1'b1;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      code_q      <= code_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  // A mode strobe restarts the pattern and swallows any coincident tick.
  always_comb begin
    mode_d      = mode_q;
    code_d      = code_q;
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    blink_d     = blink_q;
    done_d      = 1'b0;

    if (i_mode_vld) begin
      mode_d      = i_mode;
      code_d      = i_code;
      tick_cnt_d  = '0;
      pulse_cnt_d = '0;
      blink_d     = 1'b1;
      state_d     = (i_mode == MODE_CODE && i_code == 4'd0) ? ST_PAUSE : ST_ON;
    end else begin
      case (mode_q)
        MODE_BLINK: begin
          if (i_tick) begin
            if (tick_cnt_q == BLINK_LAST) begin
              tick_cnt_d = '0;
              blink_d    = ~blink_q;
            end else begin
              tick_cnt_d = tick_cnt_q + TICK_ONE;
            end
          end
        end
        MODE_CODE: begin
          if (i_tick) begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
            case (state_q)
              ST_ON: begin
                if (tick_cnt_q == ON_LAST) begin
                  tick_cnt_d  = '0;
                  pulse_cnt_d = pulse_cnt_q + 4'd1;
                  state_d     = (pulse_cnt_q + 4'd1 == code_q) ? ST_PAUSE : ST_OFF;
                end
              end
              ST_OFF: begin
                if (tick_cnt_q == OFF_LAST) begin
                  tick_cnt_d = '0;
                  state_d    = ST_ON;
                end
              end
              ST_PAUSE: begin
                if (tick_cnt_q == PAUSE_LAST) begin
                  tick_cnt_d  = '0;
                  pulse_cnt_d = '0;
                  done_d      = 1'b1;
                  state_d     = (code_q == 4'd0) ? ST_PAUSE : ST_ON;
                end
              end
              default: begin
                tick_cnt_d = '0;
                state_d    = ST_ON;
              end
            endcase
          end
        end
        default: begin
          tick_cnt_d  = '0;
          pulse_cnt_d = '0;
        end
      endcase
    end
  end

  // LED level derived from the next-state values so the register shows it one cycle later.
  always_comb begin
    led_raw = 1'b0;
    case (mode_d)
      MODE_OFF:   led_raw = 1'b0;
      MODE_ON:    led_raw = 1'b1;
      MODE_BLINK: led_raw = blink_d;
      MODE_CODE:  led_raw = (state_d == ST_ON);
      default:    led_raw = 1'b0;
    endcase
  end

`ifdef LED_DIM_EN
  led_pwm_gate u_pwm_gate (
    .i_sys_clk (i_sys_clk),
    .i_rst     (i_rst),
    .i_duty    (i_duty),
    .o_gate    (led_gate)
  );
`else
  logic unused_duty;
  assign unused_duty = ^i_duty;
  assign led_gate    = 1'b1;
`endif

  assign led_d        = led_raw & led_gate;
  assign o_led        = led_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus randomized mode/tick
// traffic, checked against a tick-time pattern model.
module tb_led_pattern_ctrl;

  localparam int BLINK = 5;
  localparam int ON    = 2;
  localparam int OFF   = 3;
  localparam int PAUSE = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       vld = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] code = 4'd0;
  logic [7:0] duty = 8'd255;
  logic       led;
  logic       done;

  int npass = 0;
  int ntotal = 0;

  // model state: pattern time in ticks since the last mode strobe
  int m_mode = 0;
  int m_code = 0;
  int m_t = 0;
  int m_pwm = 0;
  logic m_led = 1'b0;
  logic m_done = 1'b0;

  led_pattern_ctrl #(
    .BLINK_TICKS (BLINK),
    .ON_TICKS    (ON),
    .OFF_TICKS   (OFF),
    .PAUSE_TICKS (PAUSE)
  ) dut (
    .i_sys_clk    (clk),
    .i_rst        (rst),
    .i_tick       (tick),
    .i_mode_vld   (vld),
    .i_mode       (mode),
    .i_code       (code),
    .i_duty       (duty),
    .o_led        (led),
    .o_frame_done (done)
  );

  always #5 clk = ~clk;

  function automatic int frame_len(input int c);
    if (c == 0) return PAUSE;
    return c * ON + (c - 1) * OFF + PAUSE;
  endfunction

  function automatic logic pattern_led(input int md, input int c, input int t);
    int p;
    case (md)
      1: return 1'b1;
      2: return ((t / BLINK) % 2) == 0;
      3: begin
        if (c == 0) return 1'b0;
        p = t % frame_len(c);
        for (int k = 0; k < c; k++)
          if (p >= k * (ON + OFF) && p < k * (ON + OFF) + ON) return 1'b1;
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, got, exp, $time);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  // Drive inputs (called at a negedge), clock once, update model, check outputs.
  task automatic step(input logic v, input logic [1:0] md, input logic [3:0] c, input logic tk);
    logic gate;
    vld = v; mode = md; code = c; tick = tk;
    @(posedge clk);
    if (v) begin
      m_mode = int'(md); m_code = int'(c); m_t = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (tk && (m_mode == 2 || m_mode == 3)) begin
        m_t++;
        if (m_mode == 3) m_done = (m_t % frame_len(m_code)) == 0;
      end
    end
`ifdef LED_DIM_EN
    gate = (m_pwm < int'(duty));
`else
    gate = 1'b1;
`endif
    m_pwm = (m_pwm + 1) % 256;
    m_led = pattern_led(m_mode, m_code, m_t) & gate;
    #1;
    check("led", led, m_led);
    check("frame_done", done, m_done);
    @(negedge clk);
    vld = 1'b0; tick = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_code = 0; m_t = 0; m_pwm = 0; m_led = 1'b0; m_done = 1'b0;
  endtask

  int ndone;
  logic [1:0] rmode;
  logic [3:0] rcode;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_led", led, 1'b0);
    check("reset_done", done, 1'b0);
    rst = 1'b0;
    model_reset();

    // OFF after reset until the first strobe, even with ticks
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 4'd0, 1'b1);

    // ON, then asynchronous reset mid-run
    step(1'b1, 2'd1, 4'd0, 1'b0);
    check("on_led", led, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 4'd0, i[0]);
    rst = 1'b1;
    #1;
    check("async_rst_led", led, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 2'd1, 4'd5, 1'b1);

    // BLINK with a tick every 4 clocks
    duty = 8'd64;
    step(1'b1, 2'd2, 4'd0, 1'b0);
    for (int i = 0; i < 90; i++) step(1'b0, 2'd0, 4'd0, (i % 4) == 3);

    // CODE 3: 66 back-to-back ticks give three frames
    ndone = 0;
    step(1'b1, 2'd3, 4'd3, 1'b0);
    for (int i = 0; i < 66; i++) begin
      step(1'b0, 2'd0, 4'd0, 1'b1);
      if (done) ndone++;
    end
    check_int("code3_frames", ndone, 3);

    // CODE 0: LED dark, frame_done every PAUSE ticks
    ndone = 0;
    step(1'b1, 2'd3, 4'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 2'd0, 4'd0, 1'b1);
      if (done) ndone++;
    end
    check_int("code0_frames", ndone, 3);

    // strobe coincident with a tick while in CODE ST_ON
    step(1'b1, 2'd3, 4'd2, 1'b0);
    step(1'b0, 2'd0, 4'd0, 1'b1);
    step(1'b1, 2'd2, 4'd0, 1'b1);
    check("vld_wins_led", led, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 4'd0, 1'b1);

    // duty 0 darkens every mode in the dimmed build
    duty = 8'd0;
    step(1'b1, 2'd1, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 4'd0, 1'b0);

    // randomized segments
    for (int seg = 0; seg < 16; seg++) begin
      rmode = 2'($urandom_range(0, 3));
      rcode = 4'($urandom_range(0, 5));
      duty  = 8'($urandom);
      step(1'b1, rmode, rcode, 1'($urandom));
      for (int i = 0; i < 160; i++) begin
        if ($urandom_range(0, 99) == 0) begin
          rmode = 2'($urandom_range(0, 3));
          rcode = 4'($urandom_range(0, 5));
          step(1'b1, rmode, rcode, 1'($urandom));
        end else begin
          step(1'b0, 2'($urandom), 4'($urandom), $urandom_range(0, 2) != 0);
        end
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
